// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with wait timeout.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_WAIT     = 15,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              arb_err
);

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 255 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
            $error("mem_port_arbiter: MAX_WAIT must be 1..255, STARVE_LIMIT 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [7:0] MAX_WAIT8 = 8'(MAX_WAIT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       fetch_force;
    logic       pick_d;
    logic       pick_i;
    logic       done;
    logic       tmo;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE8 = 8'(STARVE_LIMIT);
    logic [7:0] starve_cnt;

    assign fetch_force = (starve_cnt >= STARVE8);

    // Counts data grants that bypassed a waiting fetch; any fetch grant or a dropped i_req resets it.
    always_ff @(posedge clk) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!i_req)
            starve_cnt <= '0;
        else if (state == IDLE && pick_i)
            starve_cnt <= '0;
        else if (state == IDLE && pick_d && starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 8'd1;
    end
`else
    assign fetch_force = 1'b0;
`endif

    always_comb begin
        pick_d = d_req && !(i_req && fetch_force);
        pick_i = i_req && !pick_d;
        done   = mem_ready;
        tmo    = !mem_ready && (wait_cnt >= MAX_WAIT8);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            i_gnt     <= 1'b0;
            i_valid   <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            arb_err   <= 1'b0;
        end else begin
            i_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            arb_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= BUSY_D;
                        d_gnt     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        wait_cnt  <= '0;
                    end else if (pick_i) begin
                        state     <= BUSY_I;
                        i_gnt     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        wait_cnt  <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done || tmo) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        arb_err <= tmo;
                        // Writes and timeouts both return zero data.
                        if (state == BUSY_D) begin
                            d_valid <= 1'b1;
                            d_rdata <= (done && !mem_we) ? mem_rdata : '0;
                        end else begin
                            i_valid <= 1'b1;
                            i_rdata <= done ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// single transactions checked against a transaction-level timing model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 15;
    localparam int SL = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_valid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          arb_err;

    int checks = 0;
    int errs   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            gnt_t;
        int            val_t;
        bit            gnt_d;
        bit            val_d;
        bit            err;
        logic [DW-1:0] rdata;
        logic [AW-1:0] ma;
        bit            mwe;
        logic [DW-1:0] mwd;
        bit            mreq_v;
    } obs_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from an IDLE cycle and a memory that answers k cycles after the grant cycle.
    task automatic run_txn(input bit is_d, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int k, input logic [DW-1:0] rd,
                           output obs_t o);
        int t = 0;
        o = '{gnt_t: -1, val_t: -1, gnt_d: 0, val_d: 0, err: 0, rdata: '0, ma: '0, mwe: 0, mwd: '0, mreq_v: 0};
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        while (o.val_t < 0 && t < 60) begin
            step();
            t++;
            if (o.gnt_t < 0 && (i_gnt || d_gnt)) begin
                o.gnt_t = t; o.gnt_d = d_gnt;
                o.ma = mem_addr; o.mwe = mem_we; o.mwd = mem_wdata;
                i_req = 1'b0; d_req = 1'b0;
            end
            if (i_valid || d_valid) begin
                o.val_t = t; o.val_d = d_valid; o.err = arb_err;
                o.rdata = d_valid ? d_rdata : i_rdata;
                o.mreq_v = mem_req;
            end
            mem_ready = (o.gnt_t >= 0 && o.val_t < 0 && t == o.gnt_t + k);
            mem_rdata = mem_ready ? rd : $urandom;
        end
        mem_ready = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*AW+4*DW+8:0] all;
        all = {i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata, mem_req, mem_we,
               mem_addr, mem_wdata, arb_err, {(AW+DW-1){1'b0}}};
        checks++;
        if (all !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got %0h required 0", all);
        end
    endtask

    task automatic test_fetch();
        obs_t o;
        logic [DW-1:0] rd = $urandom;
        run_txn(1'b0, 1'b0, 32'h40, '0, 2, rd, o);
        checks++; if (o.gnt_t !== 1 || o.gnt_d) begin errs++; $display("FAIL fetch_gnt: cycle %0d d=%0d required cycle 1 fetch", o.gnt_t, o.gnt_d); end
        checks++; if (o.val_t !== 4 || o.val_d) begin errs++; $display("FAIL fetch_valid: cycle %0d required 4", o.val_t); end
        checks++; if (o.rdata !== rd) begin errs++; $display("FAIL fetch_rdata: got %0h required %0h", o.rdata, rd); end
        checks++; if (o.ma !== 32'h40 || o.mwe) begin errs++; $display("FAIL fetch_addr: got %0h we=%0d required 40 we=0", o.ma, o.mwe); end
    endtask

    task automatic test_write();
        obs_t o;
        run_txn(1'b1, 1'b1, 32'h1234, 32'hDEADBEEF, 1, 32'hFFFF_0000, o);
        checks++; if (!o.mwe || o.mwd !== 32'hDEADBEEF) begin errs++; $display("FAIL write_mem: we=%0d wdata=%0h required we=1 DEADBEEF", o.mwe, o.mwd); end
        checks++; if (o.val_t !== 3 || !o.val_d || o.rdata !== '0) begin errs++; $display("FAIL write_valid: cycle %0d rdata %0h required cycle 3 rdata 0", o.val_t, o.rdata); end
    endtask

    task automatic test_timeout();
        obs_t o;
        logic [DW-1:0] rd = $urandom;
        run_txn(1'b0, 1'b0, 32'h80, '0, 99, rd, o);
        checks++; if (o.val_t !== MW + 2 || !o.err) begin errs++; $display("FAIL timeout_err: cycle %0d err %0d required cycle %0d err 1", o.val_t, o.err, MW + 2); end
        checks++; if (o.rdata !== '0 || o.mreq_v) begin errs++; $display("FAIL timeout_data: rdata %0h mem_req %0d required 0 0", o.rdata, o.mreq_v); end
        // Ready on the very last allowed cycle is a success.
        run_txn(1'b1, 1'b0, 32'h84, '0, MW, rd, o);
        checks++; if (o.val_t !== MW + 2 || o.err || o.rdata !== rd) begin errs++; $display("FAIL ready_at_limit: cycle %0d err %0d rdata %0h required %0d 0 %0h", o.val_t, o.err, o.rdata, MW + 2, rd); end
    endtask

    task automatic test_priority();
        int t = 0, dg = -1, dv = -1, ig = -1, iv = -1;
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        while (iv < 0 && t < 30) begin
            step();
            t++;
            if (d_gnt && dg < 0) begin dg = t; d_req = 1'b0; end
            if (i_gnt && ig < 0) begin ig = t; i_req = 1'b0; end
            if (d_valid) dv = t;
            if (i_valid) iv = t;
            mem_ready = (iv < 0) && (t == dg || t == ig);
            mem_rdata = $urandom;
        end
        mem_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;
        checks++; if (dg !== 1 || dv !== 2) begin errs++; $display("FAIL prio_data_first: d_gnt %0d d_valid %0d required 1 2", dg, dv); end
        checks++; if (ig !== 3 || iv !== 4) begin errs++; $display("FAIL prio_fetch_next: i_gnt %0d i_valid %0d required 3 4", ig, iv); end
    endtask

    task automatic test_starve();
        bit got[8];
        int n = 0, t = 0, dcount = 0;
        bit exp_i;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b1;
        while (n < 8 && t < 60) begin
            step();
            t++;
            if (i_gnt || d_gnt) begin got[n] = d_gnt; n++; end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) step();
        mem_ready = 1'b0;
        checks++; if (n !== 8) begin errs++; $display("FAIL starve_grant_count: got %0d required 8", n); end
        for (int g = 0; g < n; g++) begin
            exp_i = GUARD && (dcount == SL);
            dcount = exp_i ? 0 : dcount + 1;
            checks++;
            if (got[g] !== !exp_i) begin errs++; $display("FAIL starve_pattern[%0d]: data=%0d required data=%0d", g, got[g], !exp_i); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit seen = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h55AA;
        step();
        checks++; if (!d_gnt || !mem_req) begin errs++; $display("FAIL rstmid_gnt: d_gnt %0d mem_req %0d required 1 1", d_gnt, mem_req); end
        d_req = 1'b0;
        step();
        reset = 1'b0; mem_ready = 1'b1;
        step();
        checks++; if ({mem_req, mem_we, d_valid, arb_err, d_gnt} !== 5'b0) begin errs++; $display("FAIL rstmid_outputs: got %b required 00000", {mem_req, mem_we, d_valid, arb_err, d_gnt}); end
        reset = 1'b1;
        repeat (3) begin step(); if (d_valid || i_valid || arb_err || mem_req) seen = 1; end
        mem_ready = 1'b0;
        checks++; if (seen) begin errs++; $display("FAIL rstmid_no_valid: activity after abort, required none"); end
        run_txn(1'b0, 1'b0, 32'h44, '0, 0, 32'hA5A5, o);
        checks++; if (o.gnt_t !== 1 || o.val_t !== 2) begin errs++; $display("FAIL rstmid_idle: gnt %0d valid %0d required 1 2", o.gnt_t, o.val_t); end
    endtask

    task automatic test_withdraw();
        bit seen_i = 0, dv = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        step();
        d_req = 1'b0; i_req = 1'b1;
        step();
        if (i_gnt) seen_i = 1;
        i_req = 1'b0; mem_ready = 1'b1;
        step();
        dv = d_valid;
        mem_ready = 1'b0;
        repeat (5) begin step(); if (i_gnt || mem_req) seen_i = 1; end
        checks++; if (!dv) begin errs++; $display("FAIL withdraw_dvalid: got 0 required 1"); end
        checks++; if (seen_i) begin errs++; $display("FAIL withdraw_no_gnt: fetch granted, required none"); end
    endtask

    task automatic test_ready_idle();
        bit seen = 0;
        mem_ready = 1'b1;
        repeat (3) begin step(); if (i_valid || d_valid || arb_err || mem_req) seen = 1; end
        mem_ready = 1'b0;
        checks++; if (seen) begin errs++; $display("FAIL ready_in_idle: response seen, required none"); end
    endtask

    task automatic test_random();
        obs_t o;
        bit is_d, we, tmo;
        int k, exp_v;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd, exp_rd;
        for (int n = 0; n < 30; n++) begin
            is_d = 1'($urandom); we = 1'($urandom); k = $urandom_range(0, MW + 3);
            a = $urandom; wd = $urandom; rd = $urandom;
            repeat ($urandom_range(0, 2)) step();
            run_txn(is_d, we, a, wd, k, rd, o);
            tmo    = (k > MW);
            exp_v  = tmo ? MW + 2 : k + 2;
            exp_rd = (tmo || (is_d && we)) ? '0 : rd;
            checks++; if (o.gnt_t !== 1 || o.gnt_d !== is_d || o.ma !== a || o.mwe !== (is_d && we)) begin
                errs++; $display("FAIL rand%0d_grant: t=%0d d=%0d addr=%0h we=%0d required 1 %0d %0h %0d", n, o.gnt_t, o.gnt_d, o.ma, o.mwe, is_d, a, is_d && we); end
            checks++; if (o.val_t !== exp_v || o.val_d !== is_d || o.err !== tmo) begin
                errs++; $display("FAIL rand%0d_valid: t=%0d d=%0d err=%0d required %0d %0d %0d", n, o.val_t, o.val_d, o.err, exp_v, is_d, tmo); end
            checks++; if (o.rdata !== exp_rd) begin
                errs++; $display("FAIL rand%0d_rdata: got %0h required %0h", n, o.rdata, exp_rd); end
            if (is_d && we) begin
                checks++; if (o.mwd !== wd) begin errs++; $display("FAIL rand%0d_wdata: got %0h required %0h", n, o.mwd, wd); end
            end
        end
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        reset = 1'b1;
        step();
        test_fetch();
        test_write();
        test_timeout();
        test_priority();
        step();
        test_starve();
        test_reset_mid();
        test_withdraw();
        test_ready_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, wait-cycle limit before timeout (1..255).
REQ-004 SHALL have parameter STARVE_LIMIT, default 3, consecutive data grants tolerated while fetch waits.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 i_req  input  1  fetch request; held until i_gnt.
REQ-008 i_addr  input  ADDR_W  fetch address.
REQ-009 i_gnt  output  1  one-cycle fetch grant pulse.
REQ-010 i_valid  output  1  one-cycle fetch completion pulse.
REQ-011 i_rdata  output  DATA_W  fetched instruction; valid with i_valid.
REQ-012 d_req / d_we  input  1 / 1  data request / write enable; held until d_gnt.
REQ-013 d_addr / d_wdata  input  ADDR_W / DATA_W  data address / store data.
REQ-014 d_gnt / d_valid  output  1 / 1  data grant pulse / completion pulse.
REQ-015 d_rdata  output  DATA_W  load data; valid with d_valid.
REQ-016 mem_req / mem_we  output  1 / 1  memory request level / write strobe.
REQ-017 mem_addr / mem_wdata  output  ADDR_W / DATA_W  registered memory address / write data.
REQ-018 mem_rdata / mem_ready  input  DATA_W / 1  memory read data / access-complete.
REQ-019 arb_err  output  1  one-cycle timeout pulse.

Function
REQ-020 FSM SHALL have states IDLE, BUSY_I, BUSY_D; IDLE->BUSY_x on grant, BUSY_x->IDLE on mem_ready or timeout.
REQ-021 In IDLE, d_req SHALL win over i_req (data priority), except per REQ-031.
REQ-022 On grant, address/we/wdata SHALL be registered; x_gnt pulses high exactly in the first BUSY cycle.
REQ-023 mem_req SHALL be high for every BUSY cycle and low in IDLE; mem_we high only in BUSY_D with captured d_we=1.
REQ-024 Latency: request sampled at edge N -> gnt and mem_req in cycle N+1; mem_ready sampled high at cycle N+1+k -> x_valid in cycle N+2+k.
REQ-025 x_rdata SHALL register mem_rdata on the mem_ready cycle; writes return d_valid with d_rdata=0.
REQ-026 One IDLE cycle SHALL separate consecutive transactions; requests during BUSY are ignored, not queued.
REQ-027 Wait counter (8 bit) SHALL clear on grant, increment each BUSY cycle with mem_ready low.
REQ-028 Counter reaching MAX_WAIT with mem_ready low SHALL force IDLE, pulse arb_err and x_valid with x_rdata=0.
REQ-029 mem_ready in IDLE SHALL be ignored; mem_ready coincident with timeout SHALL count as success (no arb_err).
REQ-030 Requester dropping req before grant SHALL be treated as withdrawn; no grant issued.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, all outputs 0, counters 0, including mid-transaction (no valid issued for aborted access).

Configuration
REQ-031 With macro MEM_ARB_STARVE_GUARD_EN defined: starvation counter increments per data grant while i_req high, clears on fetch grant or i_req low; at STARVE_LIMIT the next arbitration SHALL grant fetch despite d_req. Without it: strict data priority, no counter logic.

Verification
REQ-033 i_req, addr 0x40, mem_ready 2 cycles after mem_req -> i_gnt cycle 1, i_valid cycle 4, i_rdata=mem_rdata.
REQ-034 i_req and d_req same cycle -> d_gnt first; i_gnt after d_valid plus one IDLE cycle.
REQ-035 d_we=1, wdata 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_valid with d_rdata=0.
REQ-036 mem_ready never asserted, MAX_WAIT=15 -> arb_err and x_valid 16 cycles after grant, mem_req low after.
REQ-037 Guard enabled, d_req and i_req continuously high -> grant pattern D,D,D,I repeating; disabled -> D only.
REQ-038 reset=0 during BUSY_D -> next cycle mem_req=0, no d_valid, FSM IDLE.
